mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_timer.sv | 31 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int WIDTH            = 16;
  localparam int TIMEOUT_DEF      = 15;
  localparam int STARVE_LIMIT_DEF = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    RESP    = 3'd3,
    ERR     = 3'd4
  } state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog for a memory transaction: counts stalled BUSY cycles and flags the last allowed one.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != CW'(TIMEOUT))) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Asserted on the stalled cycle that would make the count reach TIMEOUT.
  assign expired = en && (cnt_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory, with starvation guard and timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_done,
  input  logic             dm_rd,
  input  logic             dm_wr,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             dm_done,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_done,
  output logic             err
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  state_t        state_reg;
  logic [SW-1:0] starve_reg;

  logic dm_req;
  logic dm_illegal;
  logic starved;
  logic grant_if;
  logic busy;
  logic expired;

  assign dm_req     = dm_rd | dm_wr;
  assign dm_illegal = dm_rd & dm_wr;
  assign starved    = (starve_reg == SW'(STARVE_LIMIT));
  assign grant_if   = if_req && (!dm_req || starved);
  assign busy       = (state_reg == BUSY_IF) || (state_reg == BUSY_DM);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy),
    .en      (busy && !mem_done),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      starve_reg <= '0;
      if_rdata   <= '0;
      if_done    <= 1'b0;
      dm_rdata   <= '0;
      dm_done    <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (dm_illegal) begin
            state_reg <= ERR;
            err       <= 1'b1;
          end else if (grant_if) begin
            state_reg  <= BUSY_IF;
            mem_req    <= 1'b1;
            mem_wr     <= 1'b0;
            mem_addr   <= if_addr;
            starve_reg <= '0;
          end else if (dm_req) begin
            state_reg <= BUSY_DM;
            mem_req   <= 1'b1;
            mem_wr    <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            // A data win over a pending fetch is one more loss for fetch.
            if (if_req && !starved) starve_reg <= starve_reg + SW'(1);
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (mem_done) begin
            state_reg <= RESP;
            mem_req   <= 1'b0;
            if (state_reg == BUSY_IF) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!mem_wr) dm_rdata <= mem_rdata;
              dm_done <= 1'b1;
            end
          end else if (expired) begin
            state_reg <= ERR;
            mem_req   <= 1'b0;
            err       <= 1'b1;
          end
        end
        RESP: state_reg <= IDLE;
        default: begin
          state_reg <= ERR;
          mem_req   <= 1'b0;
          err       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed scoreboard bench for mem_arbiter against a transaction-level memory model.
module tb_mem_arbiter;

  localparam int TIMEOUT      = 15;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req, dm_rd, dm_wr, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, dm_done, mem_req, mem_wr, err;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory (updated at issue time) and the responder's memory (updated by DUT writes).
  logic [15:0] ref_mem   [0:65535];
  logic [15:0] mem_model [0:65535];
  logic [15:0] if_q [$];
  logic [15:0] dm_q [$];
  logic [15:0] last_dm;

  int resp_delay = 0;
  bit resp_hold  = 1'b0;
  bit resp_rand  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // sel: 0 = mem_req, 1 = if_done, 2 = dm_done. Returns edges waited.
  task automatic wait_for(input int sel, input string name, output int n);
    logic s;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
      case (sel)
        0:       s = mem_req;
        1:       s = if_done;
        default: s = dm_done;
      endcase
    end while (!s && n < 100);
    if (!s) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timed out after %0d cycles, expected the event", name, n);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_dm = 16'h0000;
  endtask

  // Memory responder: answers each transaction after a chosen number of extra BUSY cycles.
  logic [15:0] r_a, r_wd;
  logic        r_w;
  int          r_d;
  bit          r_live;
  initial begin
    mem_done = 1'b0; mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (mem_req && !resp_hold) begin
        r_a = mem_addr; r_w = mem_wr; r_wd = mem_wdata;
        r_d = resp_rand ? int'($urandom_range(0, 3)) : resp_delay;
        r_live = 1'b1;
        for (int i = 0; i < r_d; i++) begin
          @(negedge clk);
          if (!mem_req) begin r_live = 1'b0; break; end
          check("mem_addr_stable", mem_addr, r_a);
          check("mem_wr_stable", mem_wr, r_w);
          check("mem_wdata_stable", mem_wdata, r_wd);
        end
        if (r_live) begin
          mem_rdata = mem_model[r_a];
          if (r_w) mem_model[r_a] = r_wd;
          mem_done = 1'b1;
          @(negedge clk);
          mem_done = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end else if (resp_rand && !mem_req && $urandom_range(0, 7) == 0) begin
        // Stray completion outside a transaction must be ignored.
        mem_done = 1'b1; mem_rdata = 16'($urandom);
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (if_done || dm_done) check("done_exclusive", if_done & dm_done, 0);
      if (if_done) begin
        if (if_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL if_done_unexpected: got a pulse, expected none");
        end else check("if_rdata", if_rdata, if_q.pop_front());
      end
      if (dm_done) begin
        if (dm_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dm_done_unexpected: got a pulse, expected none");
        end else check("dm_rdata", dm_rdata, dm_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int          n, busy_cnt, k;
  bit          wr_seen;
  logic [15:0] exp_addr;

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ref_mem[a]   = a[15:0] ^ 16'hA5A5;
      mem_model[a] = a[15:0] ^ 16'hA5A5;
    end
    if_req = 0; dm_rd = 0; dm_wr = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
    last_dm = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_err", err, 0);
    check("rst_if_done", if_done, 0);
    check("rst_dm_done", dm_done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    rst = 1'b1;

    // Lone fetch: done in the second BUSY cycle, so if_done shows on the third edge.
    ref_mem[16'h0040] = 16'h1234; mem_model[16'h0040] = 16'h1234;
    resp_delay = 1;
    @(negedge clk);
    if_addr = 16'h0040; if_req = 1'b1; if_q.push_back(16'h1234);
    n = 0; wr_seen = 0;
    do begin
      @(posedge clk); #2; n++;
      if (mem_req && mem_wr) wr_seen = 1;
    end while (!if_done && n < 50);
    check("fetch_latency", n, 3);
    check("fetch_mem_wr", wr_seen, 0);
    check("fetch_mem_addr", mem_addr, 16'h0040);
    @(negedge clk); if_req = 1'b0;

    // Contention: data write first, fetch after RESP + IDLE.
    resp_delay = 0;
    @(negedge clk);
    if_addr = 16'h0044; if_req = 1'b1;
    dm_addr = 16'h0100; dm_wdata = 16'hBEEF; dm_wr = 1'b1;
    ref_mem[16'h0100] = 16'hBEEF;
    dm_q.push_back(last_dm);
    if_q.push_back(ref_mem[16'h0044]);
    wait_for(0, "cont_grant", n);
    check("cont_mem_wr", mem_wr, 1);
    check("cont_mem_addr", mem_addr, 16'h0100);
    check("cont_mem_wdata", mem_wdata, 16'hBEEF);
    wait_for(2, "cont_dm_done", n);
    @(negedge clk); dm_wr = 1'b0;
    wait_for(0, "cont_fetch_grant", n);
    check("cont_fetch_gap", n, 2);
    check("cont_fetch_addr", mem_addr, 16'h0044);
    check("cont_fetch_wr", mem_wr, 0);
    wait_for(1, "cont_if_done", n);
    @(negedge clk); if_req = 1'b0;

    // Starvation: three data wins, then fetch; counter restarts so the pattern repeats.
    @(negedge clk);
    dm_addr = 16'h0104; dm_rd = 1'b1; if_addr = 16'h0048; if_req = 1'b1;
    last_dm = ref_mem[16'h0104];
    for (int i = 0; i < 6; i++) dm_q.push_back(last_dm);
    if_q.push_back(ref_mem[16'h0048]);
    if_q.push_back(ref_mem[16'h004A]);
    for (int g = 0; g < 8; g++) begin
      wait_for(0, "starve_grant", n);
      exp_addr = (g == 3) ? 16'h0048 : (g == 7) ? 16'h004A : 16'h0104;
      check("starve_grant_addr", mem_addr, exp_addr);
      if (g == 3 || g == 7) begin
        if (g == 7) begin @(negedge clk); dm_rd = 1'b0; end
        wait_for(1, "starve_if_done", n);
        @(negedge clk);
        if (g == 3) if_addr = 16'h004A;
        else        if_req  = 1'b0;
      end else begin
        wait_for(2, "starve_dm_done", n);
      end
    end

    // Illegal simultaneous read and write.
    @(negedge clk);
    dm_addr = 16'h0108; dm_rd = 1'b1; dm_wr = 1'b1;
    @(posedge clk); #2;
    check("illegal_err", err, 1);
    check("illegal_mem_req", mem_req, 0);
    @(negedge clk); dm_rd = 1'b0; dm_wr = 1'b0; if_addr = 16'h0040; if_req = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      check("err_absorb_err", err, 1);
      check("err_absorb_mem_req", mem_req, 0);
    end
    apply_reset();
    @(posedge clk); #2;
    check("illegal_cleared", err, 0);

    // Timeout: memory never answers.
    resp_hold = 1'b1;
    @(negedge clk); dm_addr = 16'h0108; dm_rd = 1'b1;
    wait_for(0, "to_grant", n);
    busy_cnt = 1; k = 0;
    do begin
      @(posedge clk); #2; k++;
      if (mem_req) busy_cnt++;
    end while (!err && k < 40);
    check("to_busy_cycles", busy_cnt, TIMEOUT);
    check("to_err", err, 1);
    check("to_mem_req", mem_req, 0);
    @(negedge clk); dm_rd = 1'b0; resp_hold = 1'b0; if_req = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
      check("to_absorb", {err, mem_req}, 2'b10);
    end
    apply_reset();
    @(posedge clk); #2;
    check("to_cleared", err, 0);

    // Asynchronous reset in the middle of a fetch.
    resp_delay = 6;
    @(negedge clk); if_addr = 16'h0050; if_req = 1'b1;
    wait_for(0, "rst_mid_grant", n);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    if_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    last_dm = 16'h0000;
    repeat (8) @(negedge clk);
    resp_delay = 1;
    if_addr = 16'h0052; if_req = 1'b1;
    if_q.push_back(ref_mem[16'h0052]);
    wait_for(1, "rst_fresh_done", n);
    check("rst_fresh_latency", n, 3);
    @(negedge clk); if_req = 1'b0;

    // Randomized traffic on both ports with random memory latency and stray completions.
    resp_rand = 1'b1;
    fork
      begin
        logic [15:0] fa;
        int nf;
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          @(negedge clk);
          fa = 16'h0040 + 16'($urandom_range(0, 15));
          if_addr = fa; if_req = 1'b1;
          if_q.push_back(ref_mem[fa]);
          wait_for(1, "rand_if_done", nf);
          @(negedge clk); if_req = 1'b0;
        end
      end
      begin
        logic [15:0] da, dw;
        int nd;
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          @(negedge clk);
          da = 16'h0100 + 16'($urandom_range(0, 15));
          dw = 16'($urandom);
          dm_addr = da; dm_wdata = dw;
          if ($urandom_range(0, 1) == 1) begin
            ref_mem[da] = dw;
            dm_wr = 1'b1;
          end else begin
            last_dm = ref_mem[da];
            dm_rd = 1'b1;
          end
          dm_q.push_back(last_dm);
          wait_for(2, "rand_dm_done", nd);
          @(negedge clk); dm_rd = 1'b0; dm_wr = 1'b0;
        end
      end
    join
    resp_rand = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("end_if_q_empty", if_q.size(), 0);
    check("end_dm_q_empty", dm_q.size(), 0);
    check("end_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
